// File: rtl/loop_counter.sv
// ---------------------------------------------------------------------------
// loop_counter
//   Loop-index counter that sequences MLP neuron and weight addresses. Each
//   pass runs from a base value to a limit value, counting up or down, and is
//   controlled by a start/busy/done handshake. Enable stalls the count for one
//   cycle when low. The counter sits beside the layer controller FSM, and Q
//   drives the upper bits of the memory address.
//
// Parameters
//   N        counter, base and limit width in bits (default 8)
//
// Ports
//   clk      in   single clock; all state updates on its rising edge
//   rst      in   asynchronous reset, active low
//   clear    in   synchronous abort: back to IDLE, Q=0, busy/done low
//   load_en  in   capture PL into the base register (in IDLE also into Q)
//   PL       in   base (start) value
//   limit    in   end value, captured when a start is accepted
//   mode     in   1 = count up base->limit, 0 = count down limit->base
//   start    in   begin a pass; accepted only in IDLE
//   enable   in   advance Q by one step this cycle (RUN only)
//   Q        out  current index, registered
//   busy     out  high while in RUN, registered
//   tc       out  combinational: in RUN and Q is at the terminal value
//   done     out  registered one-cycle pulse when a pass completes
//   c_out    out  combinational all-ones indicator of Q
//
// Configuration
//   LOOP_CNT_AUTORELOAD_EN  when defined, reaching the terminal value reloads
//                           Q and the counter stays in RUN. Each completed
//                           pass still pulses done. Only clear or reset
//                           leaves RUN. When undefined, a single pass ends
//                           in DONE.
// ---------------------------------------------------------------------------
module loop_counter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load_en,
  input  logic [N-1:0] PL,
  input  logic [N-1:0] limit,
  input  logic         mode,
  input  logic         start,
  input  logic         enable,
  output logic [N-1:0] Q,
  output logic         busy,
  output logic         tc,
  output logic         done,
  output logic         c_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] q_q, q_d;
  logic [N-1:0] base_q, base_d;
  logic [N-1:0] lim_q, lim_d;
  logic         mode_q, mode_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  logic [N-1:0] terminal;
  logic [N-1:0] start_base;
  logic         at_terminal;
  logic         wrap_pulse;

  // An up pass ends at the captured limit. A down pass ends at the base.
  assign terminal    = mode_q ? lim_q : base_q;
  assign at_terminal = (state_q == RUN) && (q_q == terminal);

  // When load_en and start arrive together, the new PL value must seed the
  // pass. The incoming value therefore bypasses the base register here.
  assign start_base = load_en ? PL : base_q;

  // Next-state logic. clear overrides everything except the async reset.
  // load_en only writes the base register, plus Q while IDLE. It does not
  // block start or enable from acting in the same cycle.
  always_comb begin
    state_d    = state_q;
    q_d        = q_q;
    base_d     = base_q;
    lim_d      = lim_q;
    mode_d     = mode_q;
    wrap_pulse = 1'b0;

    if (clear) begin
      state_d = IDLE;
      q_d     = '0;
    end else begin
      if (load_en) begin
        base_d = PL;
        if (state_q == IDLE) begin
          q_d = PL;
        end
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            lim_d  = limit;
            mode_d = mode;
            // An inverted range has zero iterations. It goes straight
            // to DONE with Q parked on the base.
            if (start_base > limit) begin
              state_d = DONE;
              q_d     = start_base;
            end else begin
              state_d = RUN;
              q_d     = mode ? start_base : limit;
            end
          end
        end

        RUN: begin
          if (enable) begin
            if (at_terminal) begin
`ifdef LOOP_CNT_AUTORELOAD_EN
              q_d        = mode_q ? base_q : lim_q;
              wrap_pulse = 1'b1;
`else
              state_d = DONE;
`endif
            end else begin
              q_d = mode_q ? (q_q + N'(1)) : (q_q - N'(1));
            end
          end
        end

        DONE: begin
          state_d = IDLE;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // busy and done are registered. They are derived from the state being
  // entered, so each one lines up with the cycle it describes.
  always_comb begin
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE) || wrap_pulse;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      base_q  <= '0;
      lim_q   <= '0;
      mode_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      base_q  <= base_d;
      lim_q   <= lim_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Q     = q_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign tc    = at_terminal;
  assign c_out = &q_q;

endmodule

// File: tb/tb_loop_counter.sv
// Self-checking bench for loop_counter.
// Each pass is predicted from its parameters with plain arithmetic:
//   expected Q = base + enables seen (up) or limit - enables seen (down).
//   The pass length is limit - base + 1.
module tb_loop_counter;

   localparam int N = 8;

   logic         clk;
   logic         rst;
   logic         clear;
   logic         load_en;
   logic [N-1:0] PL;
   logic [N-1:0] limit;
   logic         mode;
   logic         start;
   logic         enable;
   logic [N-1:0] Q;
   logic         busy;
   logic         tc;
   logic         done;
   logic         c_out;

   int numCompared;
   int numMismatched;

   loop_counter #(.N(N)) dut (
      .clk     (clk),
      .rst     (rst),
      .clear   (clear),
      .load_en (load_en),
      .PL      (PL),
      .limit   (limit),
      .mode    (mode),
      .start   (start),
      .enable  (enable),
      .Q       (Q),
      .busy    (busy),
      .tc      (tc),
      .done    (done),
      .c_out   (c_out)
   );

   // Free-running clock with a 10 ns period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compares one observed value against the predicted value.
   // Records the comparison and reports a mismatch.
   task automatic checkOutput(input string tag, input int unsigned observed,
                              input int unsigned expected);
      numCompared++;
      if (observed !== expected) begin
         numMismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)",
                  tag, observed, expected, $time);
      end
   endtask

   // Advances one clock edge, then waits a little.
   // Outputs are sampled and inputs driven away from the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Returns every control input to its inactive value.
   task automatic applyStimulus();
      clear   = 1'b0;
      load_en = 1'b0;
      start   = 1'b0;
      enable  = 1'b0;
   endtask

   // Runs one complete pass and checks every cycle against the arithmetic
   // prediction.
   //   enPattern: 0 = random enable, 1 = always on, 2 = toggling 1,0,1,...
   //   loadWithStart: load the base in the same cycle as start.
   task automatic runPass(input int base, input int lim, input bit dirUp,
                          input int enPattern, input bit loadWithStart);
      int  len;
      int  e;
      int  cycles;
      int  expQ;
      int  termQ;
      bit  en;

      applyStimulus();
      if (!loadWithStart) begin
         load_en = 1'b1;
         PL      = N'(base);
         tick();
         load_en = 1'b0;
         checkOutput("idle_load_q", Q, base);
      end
      if (loadWithStart) begin
         load_en = 1'b1;
         PL      = N'(base);
      end
      limit = N'(lim);
      mode  = dirUp;
      start = 1'b1;
      tick();
      applyStimulus();
      // Later changes to limit/mode must not affect the running pass.
      limit = N'($urandom);
      mode  = $urandom_range(0, 1) != 0;

      if (base > lim) begin
         checkOutput("degen_q", Q, base);
         checkOutput("degen_busy", busy, 0);
         checkOutput("degen_done", done, 1);
         tick();
         checkOutput("degen_done_after", done, 0);
         checkOutput("degen_busy_after", busy, 0);
         return;
      end

      len    = lim - base + 1;
      termQ  = dirUp ? lim : base;
      e      = 0;
      cycles = 0;
      while (e < len) begin
         expQ = dirUp ? (base + e) : (lim - e);
         checkOutput("run_q", Q, expQ);
         checkOutput("run_busy", busy, 1);
         checkOutput("run_done", done, 0);
         checkOutput("run_tc", tc, (e == len - 1) ? 1 : 0);
         checkOutput("run_cout", c_out, (expQ == 255) ? 1 : 0);
         case (enPattern)
            1:       en = 1'b1;
            2:       en = (cycles % 2) == 0;
            default: en = (cycles > 2 * len) ? 1'b1 : ($urandom_range(0, 1) != 0);
         endcase
         enable = en;
         // A start during RUN must be ignored.
         start  = $urandom_range(0, 3) == 0;
         tick();
         if (en) e++;
         cycles++;
      end
      applyStimulus();
      checkOutput("end_done", done, 1);
      checkOutput("end_busy", busy, 0);
      checkOutput("end_q", Q, termQ);
      tick();
      checkOutput("post_done", done, 0);
      checkOutput("post_q", Q, termQ);
      checkOutput("post_busy", busy, 0);
   endtask

   initial begin
      int base;
      int lim;

      numCompared   = 0;
      numMismatched = 0;
      rst   = 1'b0;
      PL    = '0;
      limit = '0;
      mode  = 1'b1;
      applyStimulus();
      tick();
      checkOutput("reset_q", Q, 0);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_done", done, 0);
      checkOutput("reset_tc", tc, 0);
      rst = 1'b1;
      tick();

      // Async reset while running with Q=5.
      load_en = 1'b1; PL = 8'd2; tick();
      load_en = 1'b0; limit = 8'd9; mode = 1'b1; start = 1'b1; tick();
      start = 1'b0; enable = 1'b1; tick(); tick(); tick();
      enable = 1'b0;
      checkOutput("pre_reset_q", Q, 5);
      #2 rst = 1'b0;
      #1;
      checkOutput("async_reset_q", Q, 0);
      checkOutput("async_reset_busy", busy, 0);
      checkOutput("async_reset_done", done, 0);
      tick(); tick();
      checkOutput("held_reset_q", Q, 0);
      checkOutput("held_reset_busy", busy, 0);
      rst = 1'b1;
      tick();

`ifdef LOOP_CNT_AUTORELOAD_EN
      // Reload build: Q cycles 0,1,2 repeatedly. done pulses on each reload.
      load_en = 1'b1; PL = 8'd0; limit = 8'd2; mode = 1'b1; start = 1'b1;
      tick();
      applyStimulus();
      enable = 1'b1;
      for (int i = 0; i < 7; i++) begin
         checkOutput("reload_q", Q, i % 3);
         checkOutput("reload_busy", busy, 1);
         checkOutput("reload_done", done, (i > 0 && (i % 3) == 0) ? 1 : 0);
         tick();
      end
      applyStimulus();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      checkOutput("reload_clear_q", Q, 0);
      checkOutput("reload_clear_busy", busy, 0);
`else
      // Directed passes.
      runPass(3, 6, 1'b1, 1, 1'b0);      // up pass 3..6
      runPass(2, 5, 1'b0, 2, 1'b0);      // down pass with stalls
      runPass(250, 255, 1'b1, 1, 1'b0);  // top of range, no wrap
      runPass(7, 4, 1'b1, 1, 1'b0);      // inverted range
      runPass(9, 12, 1'b1, 1, 1'b1);     // load and start together

      // Clear in the middle of a pass, at Q=4.
      load_en = 1'b1; PL = 8'd2; tick();
      load_en = 1'b0; limit = 8'd10; mode = 1'b1; start = 1'b1; tick();
      start = 1'b0; enable = 1'b1; tick(); tick();
      enable = 1'b0;
      checkOutput("pre_clear_q", Q, 4);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      checkOutput("clear_q", Q, 0);
      checkOutput("clear_busy", busy, 0);
      checkOutput("clear_done", done, 0);
      tick();
      checkOutput("clear_no_done", done, 0);

      // Randomised passes.
      for (int p = 0; p < 25; p++) begin
         base = $urandom_range(0, 255);
         lim  = base + $urandom_range(0, 10);
         if (lim > 255) lim = 255;
         if (base > 0 && $urandom_range(0, 5) == 0) lim = $urandom_range(0, base - 1);
         runPass(base, lim, $urandom_range(0, 1) != 0, 0, $urandom_range(0, 1) != 0);
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               numCompared, numMismatched);
      $finish;
   end

endmodule
